ccd_line_reader: RTL and testbench

//   Readout end of the CCD timing interface: consumes phi_p / phi_r from the sensor clock driver,

---
 rtl/ccd_pkg.sv | 30 +++
 rtl/ccd_pix_fifo.sv | 54 +++++
 rtl/ccd_line_reader.sv | 211 +++++++++++++++++++++
 tb/tb_ccd_line_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types and defaults for the CCD line reader: FSM states, counter sizing
// and the layout of one output FIFO entry.
package ccd_pkg;

    localparam int CCD_ADC_W      = 12;
    localparam int CCD_N_DUMMY    = 32;
    localparam int CCD_N_PIXELS   = 3648;
    localparam int CCD_SAMPLE_DLY = 4;
    localparam int CCD_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_R = 3'd1,
        ST_DLY    = 3'd2,
        ST_CONV   = 3'd3,
        ST_DONE   = 3'd4
    } ccd_state_e;

    typedef struct packed {
        logic                 sol;
        logic                 eol;
        logic [CCD_ADC_W-1:0] data;
    } ccd_entry_t;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int ccd_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ccd_pix_fifo.sv
// Synchronous first-word-fall-through FIFO holding {sol, eol, data} entries.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ccd_pix_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push_s;
    logic         do_pop_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    // Head reads as zero when empty so the outputs look idle after a flush.
    assign dout_o    = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ccd_line_reader.sv
// CCD readout: syncs phi_p/phi_r, paces ADC conversions, drops dummy pixels and streams
// active pixels through a small FIFO. Define CCD_CDS_EN for correlated double sampling.
module ccd_line_reader
    import ccd_pkg::*;
#(
    parameter int ADC_W      = CCD_ADC_W,
    parameter int N_DUMMY    = CCD_N_DUMMY,
    parameter int N_PIXELS   = CCD_N_PIXELS,
    parameter int SAMPLE_DLY = CCD_SAMPLE_DLY,
    parameter int FIFO_DEPTH = CCD_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             phi_p,
    input  logic             phi_r,
    output logic             adc_conv,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_sol,
    output logic             pix_eol,
    output logic             line_done,
    output logic             overflow,
    output logic             short_line
);
    localparam int CNT_W = ccd_cnt_w(N_DUMMY + N_PIXELS);
    localparam int DLY_W = ccd_cnt_w(SAMPLE_DLY);
    localparam logic [CNT_W-1:0] FIRST_C    = CNT_W'(N_DUMMY);
    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(N_DUMMY + N_PIXELS - 1);
    localparam logic [DLY_W-1:0] DLY_LOAD_C = DLY_W'(SAMPLE_DLY - 1);

    ccd_state_e       state_q;
    logic [2:0]       phi_p_q, phi_r_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DLY_W-1:0] dly_q;
    logic             adc_conv_q, line_done_q, overflow_q, short_line_q;
    logic             push_q;
    logic [ADC_W+1:0] push_data_q;
    logic [ADC_W+1:0] head_s;
    logic [ADC_W-1:0] sample_d;
    logic             phi_p_rise_s, phi_r_fall_s, pix_done_s;
    logic             full_s, empty_s, pop_s, drop_s;
`ifdef CCD_CDS_EN
    logic [1:0]       cds_phase_q;
    logic [ADC_W-1:0] ref_q;
`endif

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi_p_q <= 3'b000;
            phi_r_q <= 3'b000;
        end else begin
            phi_p_q <= {phi_p_q[1:0], phi_p};
            phi_r_q <= {phi_r_q[1:0], phi_r};
        end
    end

    assign phi_p_rise_s = phi_p_q[1] & ~phi_p_q[2];
    assign phi_r_fall_s = ~phi_r_q[1] & phi_r_q[2];
    assign pop_s        = ~empty_s & pix_ready;
    assign drop_s       = push_q & full_s & ~pop_s;

`ifdef CCD_CDS_EN
    assign pix_done_s = (state_q == ST_CONV) && (cds_phase_q == 2'd2) && adc_valid;
`else
    assign pix_done_s = (state_q == ST_CONV) && adc_valid;
`endif

    // Value to push for the pixel just converted.
    always_comb begin
        sample_d = adc_data;
`ifdef CCD_CDS_EN
        sample_d = (adc_data > ref_q) ? '0 : (ref_q - adc_data);
`endif
    end

    // Line sequencing FSM with registered strobes and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dly_q        <= '0;
            adc_conv_q   <= 1'b0;
            line_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            short_line_q <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
`ifdef CCD_CDS_EN
            cds_phase_q  <= 2'd0;
            ref_q        <= '0;
`endif
        end else if (!enable) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dly_q        <= '0;
            adc_conv_q   <= 1'b0;
            line_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            short_line_q <= 1'b0;
            push_q       <= 1'b0;
`ifdef CCD_CDS_EN
            cds_phase_q  <= 2'd0;
`endif
        end else begin
            adc_conv_q  <= 1'b0;
            line_done_q <= 1'b0;
            push_q      <= 1'b0;
            if (drop_s) overflow_q <= 1'b1;
            if (phi_p_rise_s && state_q != ST_IDLE && state_q != ST_DONE) begin
                short_line_q <= 1'b1;
                cnt_q        <= '0;
                state_q      <= ST_WAIT_R;
`ifdef CCD_CDS_EN
                cds_phase_q  <= 2'd0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (phi_p_rise_s) begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT_R;
                        end
                    end
                    ST_WAIT_R: begin
                        if (phi_r_fall_s) begin
                            dly_q   <= DLY_LOAD_C;
                            state_q <= ST_DLY;
                        end
                    end
                    ST_DLY: begin
                        if (phi_r_fall_s) overflow_q <= 1'b1;
                        if (dly_q == '0) begin
                            adc_conv_q <= 1'b1;
                            state_q    <= ST_CONV;
                        end else begin
                            dly_q <= dly_q - DLY_W'(1);
                        end
                    end
                    ST_CONV: begin
                        if (phi_r_fall_s) overflow_q <= 1'b1;
`ifdef CCD_CDS_EN
                        // Reference sample first, then the signal sample SAMPLE_DLY later.
                        case (cds_phase_q)
                            2'd0: if (adc_valid) begin
                                ref_q       <= adc_data;
                                dly_q       <= DLY_LOAD_C;
                                cds_phase_q <= 2'd1;
                            end
                            2'd1: if (dly_q == '0) begin
                                adc_conv_q  <= 1'b1;
                                cds_phase_q <= 2'd2;
                            end else begin
                                dly_q <= dly_q - DLY_W'(1);
                            end
                            default: if (adc_valid) cds_phase_q <= 2'd0;
                        endcase
`endif
                        if (pix_done_s) begin
                            if (cnt_q >= FIRST_C) begin
                                push_q      <= 1'b1;
                                push_data_q <= {cnt_q == FIRST_C, cnt_q == LAST_C, sample_d};
                            end
                            if (cnt_q == LAST_C) begin
                                state_q <= ST_DONE;
                            end else begin
                                cnt_q   <= cnt_q + CNT_W'(1);
                                state_q <= ST_WAIT_R;
                            end
                        end
                    end
                    ST_DONE: begin
                        line_done_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= phi_p_rise_s ? ST_WAIT_R : ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    ccd_pix_fifo #(
        .W     (ADC_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (~enable),
        .push_i  (push_q),
        .din_i   (push_data_q),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign adc_conv   = adc_conv_q;
    assign line_done  = line_done_q;
    assign overflow   = overflow_q;
    assign short_line = short_line_q;
    assign pix_valid  = ~empty_s;
    assign pix_sol    = head_s[ADC_W+1];
    assign pix_eol    = head_s[ADC_W];
    assign pix_data   = head_s[ADC_W-1:0];

endmodule

// File: tb/tb_ccd_line_reader.sv
// Directed bench for ccd_line_reader with a small ADC model (reply 3 cycles after adc_conv).
module tb_ccd_line_reader;
    localparam int ADC_W = 12;

    logic             clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic             phi_p = 1'b0, phi_r = 1'b1;
    logic             adc_conv, adc_valid = 1'b0;
    logic [ADC_W-1:0] adc_data = '0, pix_data;
    logic             pix_valid, pix_ready = 1'b0, pix_sol, pix_eol;
    logic             line_done, overflow, short_line;

    int n_cmp = 0, n_err = 0;
    int conv_count = 0, done_count = 0, dbl_conv = 0, adc_timer = 0;
    logic [ADC_W-1:0] adc_q[$];
    logic [ADC_W+1:0] got[$];

    ccd_line_reader #(
        .ADC_W(ADC_W), .N_DUMMY(2), .N_PIXELS(8), .SAMPLE_DLY(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .phi_p(phi_p), .phi_r(phi_r),
        .adc_conv(adc_conv), .adc_valid(adc_valid), .adc_data(adc_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .line_done(line_done),
        .overflow(overflow), .short_line(short_line)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ADC model: one result per request, delivered 3 cycles later from adc_q.
    always @(negedge clk) begin
        adc_valid = 1'b0;
        if (adc_timer > 0) begin
            adc_timer--;
            if (adc_timer == 0) begin
                adc_valid = 1'b1;
                if (adc_q.size() > 0) adc_data = adc_q.pop_front();
                else                  adc_data = '0;
            end
        end
        if (adc_conv) begin
            if (adc_timer > 0) dbl_conv++;
            adc_timer = 3;
        end
    end

    // Event monitor on the active edge (pre-update values).
    always @(posedge clk) begin
        if (adc_conv) conv_count++;
        if (line_done) done_count++;
        if (pix_valid && pix_ready) got.push_back({pix_sol, pix_eol, pix_data});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_p();
        phi_p = 1'b1; cyc(4); phi_p = 1'b0; cyc(6);
    endtask

    task automatic pulse_r(input int lo, input int hi);
        phi_r = 1'b0; cyc(lo); phi_r = 1'b1; cyc(hi);
    endtask

    task automatic pix_slow(input int n);
        repeat (n) pulse_r(4, 24);
    endtask

    // Queue ADC results so that pixel i of the line yields 0x100+i.
    task automatic fill_line();
        adc_q.delete();
        for (int i = 0; i < 10; i++) begin
`ifdef CCD_CDS_EN
            adc_q.push_back(12'h800);
            adc_q.push_back(12'h800 - (12'h100 + 12'(i)));
`else
            adc_q.push_back(12'h100 + 12'(i));
`endif
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".conv"},  32'(adc_conv),   32'd0);
        check({tag, ".valid"}, 32'(pix_valid),  32'd0);
        check({tag, ".data"},  32'(pix_data),   32'd0);
        check({tag, ".sol"},   32'(pix_sol),    32'd0);
        check({tag, ".eol"},   32'(pix_eol),    32'd0);
        check({tag, ".done"},  32'(line_done),  32'd0);
        check({tag, ".ovf"},   32'(overflow),   32'd0);
        check({tag, ".short"}, 32'(short_line), 32'd0);
    endtask

    function automatic logic [ADC_W+1:0] ent(input logic sol, input logic eol, input int v);
        return {sol, eol, 12'(v)};
    endfunction

    initial begin
        int b, c0, d0, nconv, npix, cpp;
`ifdef CCD_CDS_EN
        cpp = 2;
`else
        cpp = 1;
`endif
        cyc(3);
        check_idle("reset");
        rst_n = 1'b1; enable = 1'b1; pix_ready = 1'b1;
        cyc(3);

        // Nominal line
        fill_line(); b = got.size(); c0 = conv_count; d0 = done_count;
        pulse_p(); pix_slow(10); cyc(10);
        check("nom.count", got.size() - b, 32'd8);
        for (int i = 0; i < 8; i++)
            check("nom.pix", 32'(got[b+i]), 32'(ent(i == 0, i == 7, 'h102 + i)));
        check("nom.done", done_count - d0, 32'd1);
        check("nom.conv", conv_count - c0, 32'(10 * cpp));
        check("nom.ovf", 32'(overflow), 32'd0);
        check("nom.short", 32'(short_line), 32'd0);

        // Backpressure for the whole line
        pix_ready = 1'b0; fill_line(); b = got.size(); d0 = done_count;
        pulse_p(); pix_slow(10); cyc(10);
        check("bp.valid", 32'(pix_valid), 32'd1);
        check("bp.head", 32'({pix_sol, pix_eol, pix_data}), 32'(ent(1'b1, 1'b0, 'h102)));
        check("bp.ovf", 32'(overflow), 32'd1);
        check("bp.done", done_count - d0, 32'd1);
        pix_ready = 1'b1; cyc(10);
        check("bp.count", got.size() - b, 32'd4);
        for (int i = 0; i < 4; i++)
            check("bp.pix", 32'(got[b+i]), 32'(ent(i == 0, 1'b0, 'h102 + i)));
        check("bp.empty", 32'(pix_valid), 32'd0);
        enable = 1'b0; cyc(1);
        check_idle("en_clr");
        enable = 1'b1; cyc(2);

        // Early phi_p after 5 phi_r
        fill_line(); b = got.size(); d0 = done_count;
        pulse_p(); pix_slow(5); fill_line(); pulse_p();
        check("short.flag", 32'(short_line), 32'd1);
        pix_slow(10); cyc(10);
        check("short.count", got.size() - b, 32'd11);
        check("short.p0", 32'(got[b+2]), 32'(ent(1'b0, 1'b0, 'h104)));
        check("short.sol", 32'(got[b+3]), 32'(ent(1'b1, 1'b0, 'h102)));
        check("short.eol", 32'(got[b+10]), 32'(ent(1'b0, 1'b1, 'h109)));
        check("short.done", done_count - d0, 32'd1);
        enable = 1'b0; cyc(1); enable = 1'b1; cyc(2);

        // Fast phi_r: pixels lost, one conversion per completed CONV
        fill_line(); b = got.size(); c0 = conv_count; d0 = done_count;
        pulse_p(); repeat (30) pulse_r(1, 1); cyc(30);
        nconv = conv_count - c0; npix = nconv / cpp;
        check("fast.ovf", 32'(overflow), 32'd1);
        check("fast.some", 32'(npix >= 3), 32'd1);
        check("fast.pushed", got.size() - b, 32'(npix - 2));
        check("fast.dbl", dbl_conv, 32'd0);
        check("fast.done", done_count - d0, 32'd0);
        enable = 1'b0; cyc(1); enable = 1'b1; cyc(2);

        // Asynchronous reset mid-line, then no activity until phi_p
        pix_ready = 1'b0; fill_line();
        pulse_p(); pix_slow(3);
        check("rst.held", 32'(pix_valid), 32'd1);
        rst_n = 1'b0; #1;
        check_idle("rst_mid");
        cyc(2); rst_n = 1'b1; cyc(20);
        c0 = conv_count; pix_slow(3);
        check("rst.noconv", conv_count - c0, 32'd0);

        // Enable low mid-line
        fill_line(); pulse_p(); pix_slow(4);
        check("en.held", 32'(pix_valid), 32'd1);
        enable = 1'b0; cyc(1);
        check_idle("en_mid");
        enable = 1'b1; c0 = conv_count; pix_slow(2);
        check("en.noconv", conv_count - c0, 32'd0);

        // Line restarts on the next phi_p
        pix_ready = 1'b1; fill_line(); b = got.size();
        pulse_p(); pix_slow(10); cyc(10);
        check("restart.count", got.size() - b, 32'd8);
        check("restart.eol", 32'(got[b+7]), 32'(ent(1'b0, 1'b1, 'h109)));

`ifdef CCD_CDS_EN
        // CDS subtraction and saturation
        adc_q.delete();
        for (int i = 0; i < 4; i++) adc_q.push_back(12'h800);
        adc_q.push_back(12'h800); adc_q.push_back(12'h300);
        adc_q.push_back(12'h100); adc_q.push_back(12'h200);
        b = got.size();
        pulse_p(); pix_slow(4); cyc(10);
        check("cds.diff", 32'(got[b]), 32'(ent(1'b1, 1'b0, 'h500)));
        check("cds.sat", 32'(got[b+1]), 32'(ent(1'b0, 1'b0, 'h000)));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
